// File: rtl/nrzi_decoder.sv
// nrzi_decoder: NRZI (NRZ-S) line decoder with optional bit unstuffing.
//   A steady line level decodes as 1, a level change as 0. With unstuffing
//   enabled, the 0 that follows STUFF_LEN consecutive 1s is dropped, and a 1
//   in that position latches a sticky stuffing error until clear_i or reset_i.
//   Optional feature macro: NRZI_DECODER_UNSTUFF_EN (undefined = pure decode).
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   en_i         bit strobe; a_i is sampled only when high
//   a_i          NRZI line level
//   clear_i      packet-boundary resync (FSM, ones counter, error flag)
//   y_o          decoded bit, meaningful when valid_o=1
//   valid_o      one-cycle pulse per delivered bit
//   stuff_err_o  sticky stuffing-violation flag
module nrzi_decoder #(
    parameter logic        RESET_LEVEL = 1'b0,
    parameter int unsigned STUFF_LEN   = 6
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic a_i,
    input  logic clear_i,
    output logic y_o,
    output logic valid_o,
    output logic stuff_err_o
);

    localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);

    logic prev_level_q, prev_level_d;
    logic y_q, y_d;
    logic valid_q, valid_d;
    logic err_q, err_d;
    logic dec_bit;

    // Unchanged level since the previous sample means a 1.
    assign dec_bit = (a_i == prev_level_q);

`ifdef NRZI_DECODER_UNSTUFF_EN

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_STUFF = 2'd1,
        S_ERR   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    // Saturating increment of the consecutive-ones counter.
    assign cnt_inc = (cnt_q < CNT_W'(STUFF_LEN)) ? cnt_q + CNT_W'(1) : cnt_q;

    // Registers: line history, FSM, counter and outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_level_q <= RESET_LEVEL;
            state_q      <= S_DATA;
            cnt_q        <= '0;
            y_q          <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_level_q <= prev_level_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            y_q          <= y_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        prev_level_d = prev_level_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        y_d          = y_q;
        valid_d      = 1'b0;
        err_d        = err_q;

        // Line continuity is tracked on every sample, even during clear/error.
        if (en_i) begin
            prev_level_d = a_i;
        end

        if (clear_i) begin
            state_d = S_DATA;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (en_i) begin
            unique case (state_q)
                S_DATA: begin
                    valid_d = 1'b1;
                    y_d     = dec_bit;
                    if (dec_bit) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(STUFF_LEN)) begin
                            state_d = S_STUFF;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                S_STUFF: begin
                    if (!dec_bit) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

`else

    // clear_i and the counter sizing have no role in the pure decoder.
    logic unused_ok;
    assign unused_ok = &{1'b0, clear_i, 1'(CNT_W)};

    // Registers: line history and outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prev_level_q <= RESET_LEVEL;
            y_q          <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_level_q <= prev_level_d;
            y_q          <= y_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    // Every strobed sample is delivered.
    always_comb begin
        prev_level_d = prev_level_q;
        y_d          = y_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        if (en_i) begin
            prev_level_d = a_i;
            y_d          = dec_bit;
            valid_d      = 1'b1;
        end
    end

`endif

    assign y_o         = y_q;
    assign valid_o     = valid_q;
    assign stuff_err_o = err_q;

endmodule
